// File: rtl/bcd_seg7_scan.sv
// Time-multiplexed 3-digit 7-segment driver for the packed BCD word from bin2bcd.
// New values are double-buffered and applied only at frame boundaries so the display never tears.
module bcd_seg7_scan #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] bcd_in,
  input  logic       bcd_vld,
  input  logic       blank_lz,
  output logic [2:0] dig_an,
  output logic [6:0] seg,
  output logic       pend,
  output logic       frame_done
);

  localparam int unsigned        CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]         SEG_MASK = {7{SEG_ACT_LOW}};
  localparam logic [2:0]         AN_MASK  = {3{SEG_ACT_LOW}};
  localparam logic [6:0]         SEG_DASH = 7'h40;

  // Handshake: bcd_vld is a one-cycle strobe with no back-pressure; every
  // strobe is accepted, the last one before a frame boundary wins, and pend
  // stays high from acceptance until that boundary consumes the value.

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       dig_idx;
  logic [9:0]       disp_reg;
  logic [9:0]       pend_reg;
  logic             pend_q;
  logic             div_wrap;
  logic             boundary;

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign boundary   = div_wrap && (dig_idx == 2'd2);
  assign frame_done = boundary;
  assign pend       = pend_q;

  // Scan counter: each digit is held for SCAN_DIV cycles, digits cycle 0,1,2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dig_idx <= 2'd0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      dig_idx <= (dig_idx == 2'd2) ? 2'd0 : dig_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Capture buffer; a strobe landing on the boundary goes straight to disp_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      pend_q   <= 1'b0;
      disp_reg <= '0;
    end else begin
      if (bcd_vld) begin
        pend_reg <= bcd_in;
      end
      if (boundary) begin
        if (bcd_vld) begin
          disp_reg <= bcd_in;
        end else if (pend_q) begin
          disp_reg <= pend_reg;
        end
        pend_q <= 1'b0;
      end else if (bcd_vld) begin
        pend_q <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

  logic [1:0] hund;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] cur_val;
  logic       cur_blank;
  logic [6:0] seg_nxt;
  logic [2:0] an_nxt;

  assign hund = disp_reg[9:8];
  assign tens = disp_reg[7:4];
  assign ones = disp_reg[3:0];

  // Hundreds==3 is mapped to an out-of-range nibble so it decodes as a dash.
  // A dash is never zero, so it naturally stops blanking of lower digits.
  always_comb begin
    cur_val   = ones;
    cur_blank = 1'b0;
    case (dig_idx)
      2'd1: begin
        cur_val   = tens;
        cur_blank = blank_lz && (hund == 2'd0) && (tens == 4'd0);
      end
      2'd2: begin
        cur_val   = (hund == 2'd3) ? 4'hF : {2'b00, hund};
        cur_blank = blank_lz && (hund == 2'd0);
      end
      default: begin
        cur_val   = ones;
        cur_blank = 1'b0;
      end
    endcase
    seg_nxt = cur_blank ? 7'h00 : seg_decode(cur_val);
    an_nxt  = 3'(3'b001 << dig_idx);
  end

  // Output register applies pin polarity; reset drives everything off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg    <= SEG_MASK;
      dig_an <= AN_MASK;
    end else begin
      seg    <= seg_nxt ^ SEG_MASK;
      dig_an <= an_nxt ^ AN_MASK;
    end
  end

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Self-checking bench for bcd_seg7_scan: directed scenarios plus random strobes,
// compared every cycle against a frame-position model with a pending-value queue.
module tb_bcd_seg7_scan;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned FRAME    = 3 * SCAN_DIV;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic [9:0] bcd_in   = '0;
  logic       bcd_vld  = 1'b0;
  logic       blank_lz = 1'b0;
  logic [2:0] dig_an;
  logic [6:0] seg;
  logic       pend;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int unsigned t_run;
  logic [9:0]  m_disp;
  logic [9:0]  exp_q[$];
  logic [6:0]  exp_seg;
  logic [2:0]  exp_an;
  logic        exp_pend;
  logic        exp_fd;
  logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_seg7_scan #(.SCAN_DIV(SCAN_DIV), .SEG_ACT_LOW(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .bcd_vld    (bcd_vld),
    .blank_lz   (blank_lz),
    .dig_an     (dig_an),
    .seg        (seg),
    .pend       (pend),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Active-high segment pattern for digit d (0=ones) of value v.
  function automatic logic [6:0] ref_seg(input int unsigned d, input logic [9:0] v, input logic blz);
    int unsigned h, tn, o, val, lim;
    logic blank;
    h     = v[9:8];
    tn    = v[7:4];
    o     = v[3:0];
    val   = (d == 0) ? o : (d == 1) ? tn : h;
    lim   = (d == 2) ? 2 : 9;
    blank = blz && ((d == 2 && h == 0) || (d == 1 && h == 0 && tn == 0));
    if (blank) return 7'h00;
    if (val > lim) return 7'h40;
    return seg_tab[val];
  endfunction

  task automatic model_clear();
    t_run   = 0;
    m_disp  = '0;
    exp_q.delete();
    exp_seg = 7'h7F;
    exp_an  = 3'b111;
  endtask

  // One clock: advance the model on the rising edge, compare on the falling edge.
  task automatic tick();
    int unsigned pos, d;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      pos     = t_run % FRAME;
      d       = pos / SCAN_DIV;
      exp_seg = ~ref_seg(d, m_disp, blank_lz);
      exp_an  = 3'b111;
      exp_an[d] = 1'b0;
      if (pos == FRAME - 1) begin
        if (bcd_vld) m_disp = bcd_in;
        else if (exp_q.size() != 0) m_disp = exp_q[$];
        exp_q.delete();
      end else if (bcd_vld) begin
        exp_q.push_back(bcd_in);
      end
      t_run++;
    end
    exp_pend = (exp_q.size() != 0);
    exp_fd   = rst_n && ((t_run % FRAME) == FRAME - 1);
    @(negedge clk);
    check_eq("seg", seg, exp_seg);
    check_eq("dig_an", dig_an, exp_an);
    check_eq("pend", pend, exp_pend);
    check_eq("frame_done", frame_done, exp_fd);
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    #1;
    check_eq("rst_seg", seg, 7'h7F);
    check_eq("rst_an", dig_an, 3'b111);
    check_eq("rst_pend", pend, 1'b0);
    check_eq("rst_fd", frame_done, 1'b0);
    model_clear();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic strobe(input logic [9:0] v);
    bcd_in  = v;
    bcd_vld = 1'b1;
    tick();
    bcd_vld = 1'b0;
  endtask

  task automatic wait_boundary();
    int n;
    n = 0;
    while (!frame_done && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check_eq("boundary_seen", frame_done, 1'b1);
  endtask

  // Starting on the boundary cycle: digit0 shows on tick 2, digit1 on 6, digit2 on 10.
  task automatic grab_frame(output logic [6:0] s0, output logic [6:0] s1, output logic [6:0] s2);
    s0 = '0;
    s1 = '0;
    s2 = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2)  s0 = seg;
      if (k == 6)  s1 = seg;
      if (k == 10) s2 = seg;
    end
  endtask

  initial begin
    logic [6:0] s0, s1, s2;
    int n;
    #2;
    apply_reset(5);

    // Digit 0 of the cleared display right after release
    tick();
    check_eq("t1_an", dig_an, 3'b110);
    check_eq("t1_seg", seg, 7'h40);
    tick();
    tick();

    strobe(10'h255);
    check_eq("t2_pend", pend, 1'b1);
    wait_boundary();
    grab_frame(s0, s1, s2);
    check_eq("t2_d0", s0, 7'h12);
    check_eq("t2_d1", s1, 7'h12);
    check_eq("t2_d2", s2, 7'h24);

    blank_lz = 1'b1;
    strobe(10'h007);
    wait_boundary();
    grab_frame(s0, s1, s2);
    check_eq("t3b_d0", s0, 7'h78);
    check_eq("t3b_d1", s1, 7'h7F);
    check_eq("t3b_d2", s2, 7'h7F);
    blank_lz = 1'b0;
    wait_boundary();
    grab_frame(s0, s1, s2);
    check_eq("t3n_d0", s0, 7'h78);
    check_eq("t3n_d1", s1, 7'h40);
    check_eq("t3n_d2", s2, 7'h40);

    // Two mid-frame strobes: only the later one reaches the display
    strobe(10'h123);
    strobe(10'h045);
    check_eq("t4_pend", pend, 1'b1);
    wait_boundary();
    grab_frame(s0, s1, s2);
    check_eq("t4_d0", s0, 7'h12);
    check_eq("t4_d1", s1, 7'h19);
    check_eq("t4_d2", s2, 7'h40);

    // Strobe on the boundary cycle itself
    wait_boundary();
    strobe(10'h198);
    check_eq("bnd_pend", pend, 1'b0);
    tick();
    check_eq("bnd_d0", seg, 7'h00);

    blank_lz = 1'b1;
    strobe(10'h3AF);
    wait_boundary();
    grab_frame(s0, s1, s2);
    check_eq("t5_d0", s0, 7'h3F);
    check_eq("t5_d1", s1, 7'h3F);
    check_eq("t5_d2", s2, 7'h3F);

    // Reset while digit 1 is shown, with a value pending
    blank_lz = 1'b0;
    n = 0;
    while (dig_an != 3'b101 && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check_eq("t6_at_d1", dig_an, 3'b101);
    bcd_in  = 10'h321;
    bcd_vld = 1'b1;
    tick();
    bcd_vld = 1'b0;
    apply_reset(3);
    n = 0;
    while (!frame_done && n < 4 * FRAME) begin
      tick();
      n++;
    end
    // frame_done is on the 12th cycle after release
    check_eq("t6_fd_lat", n, FRAME - 1);

    for (int i = 0; i < 900; i++) begin
      bcd_in  = 10'($urandom_range(0, 1023));
      bcd_vld = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if (i == 450) begin
        bcd_vld = 1'b0;
        apply_reset(2);
      end
      tick();
    end
    bcd_vld = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
